// File: rtl/seg7_pkg.sv
// seg7_pkg: seven-segment encoding, blank pattern and display mode type.
package seg7_pkg;

  typedef enum logic {MODE_STATIC = 1'b0, MODE_SCAN = 1'b1} mode_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {a..g}; a 0 bit lights that segment.
  function automatic logic [6:0] seg7_decode(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'ha: return 7'b0001000;
      4'hb: return 7'b1100000;
      4'hc: return 7'b0110001;
      4'hd: return 7'b1000010;
      4'he: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: board-side controls and display pins of the scanned display.
interface seg_scan_display_if #(parameter int NUM_DIGITS = 8);
  localparam int SEL_W = $clog2(NUM_DIGITS);
  logic [3:0] num;
  logic [SEL_W-1:0] sel;
  logic write;
  logic blank;
  logic mode;
  logic a, b, c, d, e, f, g;
  logic [NUM_DIGITS-1:0] an;
  logic [SEL_W-1:0] scan_idx;
  modport master(
    output num, sel, write, blank, mode,
    input a, b, c, d, e, f, g, an, scan_idx
  );
  modport slave(
    input num, sel, write, blank, mode,
    output a, b, c, d, e, f, g, an, scan_idx
  );
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex to active-low seven-segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);
  assign seg = seg7_decode(value);
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: per-digit hex/enable store driving a static or time-multiplexed display.
module seg_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic reset,
  seg_scan_display_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int PRESC_W = $clog2(REFRESH_DIV);
  // Storage is padded to a power of two so any sel/idx indexes in range; the pad stays disabled.
  localparam int DEPTH = 1 << SEL_W;
  localparam logic [SEL_W:0] NUM = (SEL_W + 1)'(NUM_DIGITS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_DIGITS - 1);
  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(REFRESH_DIV - 1);

  logic [3:0] digits [DEPTH];
  logic [DEPTH-1:0] en;
  logic [PRESC_W-1:0] pre;
  logic [SEL_W-1:0] scan, sel_q, idx;
  mode_e mode_q, mode_in;
  logic sel_ok, lit;
  logic [6:0] dec, seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  assign mode_in = mode_e'(bus.mode);
  assign sel_ok = {1'b0, bus.sel} < NUM;
  assign idx = mode_q == MODE_SCAN ? scan : sel_q;
  assign lit = en[idx];

  seg7_decoder u_dec (
    .value(digits[idx]),
    .seg  (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) digits[i] <= '0;
      en     <= '0;
      pre    <= '0;
      scan   <= '0;
      sel_q  <= '0;
      mode_q <= MODE_STATIC;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
    end else begin
      if (bus.write && sel_ok) begin
        digits[bus.sel] <= bus.num;
        en[bus.sel]     <= 1'b1;
      end else if (bus.blank && sel_ok) begin
        en[bus.sel] <= 1'b0;
      end
      sel_q  <= bus.sel;
      mode_q <= mode_in;
      // A mode edge restarts the scan at digit 0 with a full dwell.
      if (mode_in != mode_q || mode_in == MODE_STATIC) begin
        pre  <= '0;
        scan <= '0;
      end else if (pre == TERM) begin
        pre  <= '0;
        scan <= scan == LAST ? '0 : scan + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      seg_q <= lit ? dec : SEG_BLANK;
      an_q  <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = seg_q;
  assign bus.an = an_q;
  assign bus.scan_idx = mode_in == MODE_SCAN ? scan : bus.sel;
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: 8- and 5-digit builds driven in lockstep against an arithmetic display model.
module tb_seg_scan_display;
  localparam int DIV = 4;

  typedef struct {
    bit w;
    bit b;
    logic [2:0] sel;
    logic [3:0] num;
    logic [6:0] seg;
    logic [7:0] an;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] t_num = '0;
  logic [2:0] t_sel = '0;
  logic t_write = 1'b0, t_blank = 1'b0, t_mode = 1'b0;

  always #5 clk = ~clk;

  seg_scan_display_if #(.NUM_DIGITS(8)) i8 ();
  seg_scan_display_if #(.NUM_DIGITS(5)) i5 ();

  assign i8.num = t_num;
  assign i8.sel = t_sel;
  assign i8.write = t_write;
  assign i8.blank = t_blank;
  assign i8.mode = t_mode;
  assign i5.num = t_num;
  assign i5.sel = t_sel;
  assign i5.write = t_write;
  assign i5.blank = t_blank;
  assign i5.mode = t_mode;

  seg_scan_display #(.NUM_DIGITS(8), .REFRESH_DIV(DIV)) d8 (.clk(clk), .reset(reset), .bus(i8));
  seg_scan_display #(.NUM_DIGITS(5), .REFRESH_DIV(DIV)) d5 (.clk(clk), .reset(reset), .bus(i5));

  int nd [2] = '{8, 5};
  logic [3:0] mval [2][16];
  logic men [2][16];
  int msel = 0, mt = 0;
  logic mmode = 1'b0;
  int vectors = 0, miscompares = 0;
  logic [6:0] seg_tab [16];
  vec_t tab [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs after an edge show the model state from before that edge; the model then absorbs the edge.
  task automatic tick();
    logic [6:0] es [2];
    logic [15:0] ea [2];
    logic [15:0] all;
    int idx;
    bit lit;
    for (int u = 0; u < 2; u++) begin
      idx = mmode ? (mt / DIV) % nd[u] : msel;
      lit = idx < nd[u] && men[u][idx] === 1'b1;
      all = 16'((1 << nd[u]) - 1);
      es[u] = (reset || !lit) ? 7'h7f : seg_tab[mval[u][idx]];
      ea[u] = (reset || !lit) ? all : all & ~16'(1 << idx);
    end
    @(posedge clk);
    if (reset) begin
      for (int u = 0; u < 2; u++)
        for (int i = 0; i < 16; i++) begin
          mval[u][i] = '0;
          men[u][i] = 1'b0;
        end
      msel = 0;
      mmode = 1'b0;
      mt = 0;
    end else begin
      for (int u = 0; u < 2; u++)
        if (int'(t_sel) < nd[u]) begin
          if (t_write) begin
            mval[u][t_sel] = t_num;
            men[u][t_sel] = 1'b1;
          end else if (t_blank) men[u][t_sel] = 1'b0;
        end
      msel = int'(t_sel);
      mt = (t_mode && t_mode == mmode) ? mt + 1 : 0;
      mmode = t_mode;
    end
    #1;
    chk("seg8", 16'({i8.a, i8.b, i8.c, i8.d, i8.e, i8.f, i8.g}), 16'(es[0]));
    chk("an8", 16'(i8.an), ea[0]);
    chk("idx8", 16'(i8.scan_idx), t_mode ? 16'((mt / DIV) % 8) : 16'(t_sel));
    chk("seg5", 16'({i5.a, i5.b, i5.c, i5.d, i5.e, i5.f, i5.g}), 16'(es[1]));
    chk("an5", 16'(i5.an), ea[1]);
    chk("idx5", 16'(i5.scan_idx), t_mode ? 16'((mt / DIV) % 5) : 16'(t_sel));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idx(input int target);
    for (int i = 0; i < 100 && int'(i8.scan_idx) != target; i++) tick();
    chk("wait_idx", 16'(i8.scan_idx), 16'(target));
  endtask

  task automatic put(input bit w, input bit b, input int sel, input int num);
    t_write = w;
    t_blank = b;
    t_sel = 3'(sel);
    t_num = 4'(num);
    tick();
    t_write = 1'b0;
    t_blank = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    for (int i = 0; i < 8; i++)
      tab.push_back('{1'b1, 1'b0, 3'(i), 4'(i), seg_tab[i], ~(8'(1) << i)});
    tab.push_back('{1'b0, 1'b0, 3'd3, 4'd0, 7'b0000110, 8'hf7});
    tab.push_back('{1'b0, 1'b0, 3'd7, 4'd0, 7'b0001111, 8'h7f});
    tab.push_back('{1'b0, 1'b1, 3'd2, 4'd0, 7'b1111111, 8'hff});
    tab.push_back('{1'b1, 1'b1, 3'd5, 4'ha, 7'b0001000, 8'hdf});
    tab.push_back('{1'b1, 1'b0, 3'd2, 4'd2, 7'b0010010, 8'hfb});
    tab.push_back('{1'b0, 1'b0, 3'd0, 4'd9, 7'b0000001, 8'hfe});

    reset = 1'b1;
    run(2);
    reset = 1'b0;
    tick();
    chk("rst_seg", 16'({i8.a, i8.b, i8.c, i8.d, i8.e, i8.f, i8.g}), 16'h007f);
    chk("rst_an", 16'(i8.an), 16'h00ff);
    chk("rst_idx", 16'(i8.scan_idx), 16'h0000);
    t_mode = 1'b1;
    run(3);
    chk("rst_scan_an", 16'(i8.an), 16'h00ff);
    chk("rst_scan_idx", 16'(i8.scan_idx), 16'h0000);
    t_mode = 1'b0;
    tick();

    foreach (tab[k]) begin
      put(tab[k].w, tab[k].b, int'(tab[k].sel), int'(tab[k].num));
      tick();
      chk("tab_seg", 16'({i8.a, i8.b, i8.c, i8.d, i8.e, i8.f, i8.g}), 16'(tab[k].seg));
      chk("tab_an", 16'(i8.an), 16'(tab[k].an));
    end

    for (int i = 0; i < 8; i++) put(1'b1, 1'b0, i, 8 + i);
    t_mode = 1'b1;
    run(70);
    wait_idx(7);
    wait_idx(0);
    put(1'b0, 1'b1, 2, 0);
    run(40);
    put(1'b1, 1'b0, 2, 2);
    run(20);
    put(1'b1, 1'b1, 5, 10);
    wait_idx(5);
    put(1'b1, 1'b0, 5, 3);
    run(20);
    wait_idx(4);
    run(2);
    reset = 1'b1;
    tick();
    chk("mid_rst_seg", 16'({i8.a, i8.b, i8.c, i8.d, i8.e, i8.f, i8.g}), 16'h007f);
    chk("mid_rst_an", 16'(i8.an), 16'h00ff);
    chk("mid_rst_idx", 16'(i8.scan_idx), 16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) put(1'b1, 1'b0, i, 15 - i);
    run(10);
    t_mode = 1'b0;
    tick();
    t_mode = 1'b1;
    tick();
    chk("restart_idx", 16'(i8.scan_idx), 16'h0000);
    run(45);

    for (int i = 0; i < 1500; i++) begin
      t_write = ($urandom % 4) == 0;
      t_blank = ($urandom % 6) == 0;
      t_sel = 3'($urandom);
      t_num = 4'($urandom);
      if (($urandom % 40) == 0) t_mode = ~t_mode;
      reset = ($urandom % 250) == 0;
      tick();
    end
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
